// File: rtl/imem_fetch_sequencer.sv
// Byte-serial instruction fetch: reads four bytes per instruction from a byte-wide memory,
// assembles a big-endian word and hands it to decode over a valid/ready handshake.
module imem_fetch_sequencer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  align_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

  state_t                  state, state_next;
  logic [1:0]              byte_idx, byte_idx_next;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [23:0]             partial;
  logic                    accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      byte_idx <= 2'd0;
    end else begin
      state    <= state_next;
      byte_idx <= byte_idx_next;
    end
  end

  // A redirect overrides whatever the state machine would otherwise do.
  always_comb begin
    state_next    = state;
    byte_idx_next = byte_idx;
    mem_rd        = 1'b0;
    mem_addr      = pc;
    accept        = instr_valid && instr_ready;
    case (state)
      IDLE: begin
        if (fetch_en) begin
          state_next    = ISSUE;
          byte_idx_next = 2'd0;
        end
      end
      ISSUE: begin
        mem_rd   = 1'b1;
        mem_addr = pc + ADDR_WIDTH'(byte_idx);
        if (byte_idx == 2'd3) begin
          state_next = DRAIN;
        end else begin
          byte_idx_next = byte_idx + 2'd1;
        end
      end
      DRAIN: begin
        state_next = HOLD;
      end
      HOLD: begin
        if (accept) begin
          state_next    = fetch_en ? ISSUE : IDLE;
          byte_idx_next = 2'd0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (redirect_valid) begin
      state_next    = fetch_en ? ISSUE : IDLE;
      byte_idx_next = 2'd0;
    end
  end

  // Read data trails the strobe by a cycle, so ISSUE byte b captures byte b-1 and DRAIN takes the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      partial     <= 24'd0;
      instr       <= 32'd0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      align_err   <= 1'b0;
    end else begin
      align_err <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        pc          <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
        instr_valid <= 1'b0;
      end else begin
        if (state == ISSUE && byte_idx != 2'd0) begin
          partial <= {partial[15:0], mem_rdata};
        end
        if (state == DRAIN) begin
          instr       <= {partial, mem_rdata};
          instr_pc    <= pc;
          instr_valid <= 1'b1;
        end
        if (accept) begin
          pc          <= pc + ADDR_WIDTH'(4);
          instr_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Self-checking bench for imem_fetch_sequencer: a transaction-level model checks every cycle,
// directed scenarios pin literal addresses, instructions and latencies.
module tb_imem_fetch_sequencer;

  localparam int             AW  = 8;
  localparam logic [AW-1:0]  RPC = 8'h00;

  logic          clk;
  logic          rst_n;
  logic          fetch_en;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          align_err;

  logic [7:0]    mem [0:255];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_xfer = 0;

  logic [AW-1:0] m_pc;
  int            m_cnt;
  int            m_first;
  logic          m_align;
  logic          m_expect_rd;
  logic          p_valid;
  logic          p_ready;
  logic          p_redir;
  logic [31:0]   p_instr;
  logic [AW-1:0] p_pc;

  imem_fetch_sequencer #(.ADDR_WIDTH(AW), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_rd         (mem_rd),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .align_err      (align_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] word(input logic [7:0] a);
    return {mem[a], mem[a + 8'd1], mem[a + 8'd2], mem[a + 8'd3]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic fe, input logic rdy, input logic rv, input logic [7:0] rpc);
    fetch_en       = fe;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  // One clock cycle: compare against the model at the falling edge, then advance the model.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      checkOutput("reset_mem_rd", 32'(mem_rd), 0);
      checkOutput("reset_instr_valid", 32'(instr_valid), 0);
      m_pc        = RPC;
      m_cnt       = 0;
      m_align     = 1'b0;
      m_expect_rd = 1'b0;
      p_valid     = 1'b0;
      p_ready     = 1'b0;
      p_redir     = 1'b0;
    end else begin
      checkOutput("model_align_err", 32'(align_err), 32'(m_align));
      if (m_expect_rd) begin
        checkOutput("model_redirect_rd", 32'(mem_rd), 1);
        checkOutput("model_redirect_addr", 32'(mem_addr), 32'(m_pc));
      end
      if (p_redir) checkOutput("model_redirect_drop", 32'(instr_valid), 0);
      if (mem_rd) begin
        checkOutput("model_read_budget", 32'(m_cnt < 4), 1);
        checkOutput("model_read_addr", 32'(mem_addr), 32'(m_pc + AW'(m_cnt)));
        checkOutput("model_read_in_hold", 32'(instr_valid), 0);
      end
      if (instr_valid) begin
        checkOutput("model_instr_pc", 32'(instr_pc), 32'(m_pc));
        checkOutput("model_instr", instr, word(m_pc));
        if (!p_valid) begin
          checkOutput("model_latency", 32'(cyc - m_first), 5);
          checkOutput("model_bytes", 32'(m_cnt), 4);
        end
        if (instr_ready) n_xfer++;
      end
      if (p_valid && !p_ready && !p_redir) begin
        checkOutput("model_hold_valid", 32'(instr_valid), 1);
        checkOutput("model_hold_instr", instr, p_instr);
        checkOutput("model_hold_pc", 32'(instr_pc), 32'(p_pc));
      end
      m_align     = redirect_valid && (redirect_pc % 4 != 0);
      m_expect_rd = redirect_valid && fetch_en;
      if (redirect_valid) begin
        m_pc  = redirect_pc - AW'(redirect_pc % 4);
        m_cnt = 0;
      end else begin
        if (mem_rd) begin
          if (m_cnt == 0) m_first = cyc;
          m_cnt++;
        end
        if (instr_valid && instr_ready) begin
          m_pc  = m_pc + 8'd4;
          m_cnt = 0;
        end
      end
      p_valid = instr_valid;
      p_ready = instr_ready;
      p_redir = redirect_valid;
      p_instr = instr;
      p_pc    = instr_pc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic waitValid(input int limit, output int n);
    n = 0;
    while (!instr_valid && n < limit) begin
      step();
      n++;
    end
    if (!instr_valid) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL wait_valid: instr_valid still 0 after %0d cycles, required 1", limit);
    end
  endtask

  initial begin
    int n;
    int x0;
    logic [7:0] init_bytes [0:11];
    init_bytes = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'h20, 8'h02, 8'h00, 8'h05,
                   8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 12; i++) mem[i] = init_bytes[i];
    mem[252] = 8'hDE; mem[253] = 8'hAD; mem[254] = 8'hBE; mem[255] = 8'hEF;
    mem_rdata = 8'h00;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    #3;
    checkOutput("reset_addr", 32'(mem_addr), 32'(RPC));
    checkOutput("reset_instr", instr, 32'h0);
    checkOutput("reset_align", 32'(align_err), 0);
    step();
    step();
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    step();

    $display("[TB] sequential fetch");
    for (int i = 0; i < 4; i++) begin
      checkOutput("seq_rd", 32'(mem_rd), 1);
      checkOutput("seq_addr", 32'(mem_addr), 32'(i));
      step();
    end
    checkOutput("seq_drain_rd", 32'(mem_rd), 0);
    step();
    checkOutput("seq_valid", 32'(instr_valid), 1);
    checkOutput("seq_instr0", instr, 32'h8C010004);
    checkOutput("seq_pc0", 32'(instr_pc), 32'h0);
    step();
    waitValid(12, n);
    checkOutput("seq_latency", 32'(n), 5);
    checkOutput("seq_instr1", instr, 32'h20020005);
    checkOutput("seq_pc1", 32'(instr_pc), 32'h4);
    step();

    $display("[TB] back-pressure");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    checkOutput("bp_restart_addr", 32'(mem_addr), 32'h0);
    waitValid(12, n);
    checkOutput("bp_latency", 32'(n), 5);
    x0 = n_xfer;
    for (int i = 0; i < 6; i++) begin
      checkOutput("bp_valid", 32'(instr_valid), 1);
      checkOutput("bp_instr", instr, 32'h8C010004);
      checkOutput("bp_no_rd", 32'(mem_rd), 0);
      step();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    step();
    checkOutput("bp_one_xfer", 32'(n_xfer - x0), 1);
    checkOutput("bp_next_rd", 32'(mem_rd), 1);
    checkOutput("bp_next_addr", 32'(mem_addr), 32'h4);

    $display("[TB] redirect mid-fetch");
    step();
    step();
    checkOutput("rd_b2_addr", 32'(mem_addr), 32'h6);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h08);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    x0 = n_xfer;
    checkOutput("rd_first_rd", 32'(mem_rd), 1);
    checkOutput("rd_first_addr", 32'(mem_addr), 32'h8);
    waitValid(12, n);
    checkOutput("rd_latency", 32'(n), 5);
    checkOutput("rd_pc", 32'(instr_pc), 32'h8);
    checkOutput("rd_instr", instr, 32'h11223344);
    checkOutput("rd_no_stale_xfer", 32'(n_xfer - x0), 0);
    step();

    $display("[TB] misaligned redirect");
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h0A);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("al_pulse", 32'(align_err), 1);
    checkOutput("al_addr", 32'(mem_addr), 32'h8);
    step();
    checkOutput("al_pulse_end", 32'(align_err), 0);
    waitValid(12, n);
    checkOutput("al_pc", 32'(instr_pc), 32'h8);

    $display("[TB] redirect with transfer");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h04);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    waitValid(12, n);
    checkOutput("rx_pc4", 32'(instr_pc), 32'h4);
    x0 = n_xfer;
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h00);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    checkOutput("rx_one_xfer", 32'(n_xfer - x0), 1);
    checkOutput("rx_next_addr", 32'(mem_addr), 32'h0);
    waitValid(12, n);
    checkOutput("rx_pc0", 32'(instr_pc), 32'h0);
    checkOutput("rx_instr0", instr, 32'h8C010004);
    checkOutput("rx_still_one", 32'(n_xfer - x0), 1);

    $display("[TB] address wrap");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hFC);
    step();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      checkOutput("wrap_rd", 32'(mem_rd), 1);
      checkOutput("wrap_addr", 32'(mem_addr), 32'(8'hFC + 8'(i)));
      step();
    end
    step();
    checkOutput("wrap_pc", 32'(instr_pc), 32'hFC);
    checkOutput("wrap_instr", instr, 32'hDEADBEEF);
    step();
    checkOutput("wrap_next_addr", 32'(mem_addr), 32'h0);

    $display("[TB] fetch_en drop");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    waitValid(12, n);
    checkOutput("fe_latency", 32'(n), 5);
    checkOutput("fe_pc", 32'(instr_pc), 32'h0);
    step();
    for (int i = 0; i < 3; i++) begin
      checkOutput("fe_idle_rd", 32'(mem_rd), 0);
      checkOutput("fe_idle_valid", 32'(instr_valid), 0);
      step();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    step();
    checkOutput("fe_resume_addr", 32'(mem_addr), 32'h4);

    $display("[TB] async reset");
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_rd", 32'(mem_rd), 0);
    checkOutput("ar_addr", 32'(mem_addr), 32'(RPC));
    checkOutput("ar_instr", instr, 32'h0);
    checkOutput("ar_pc", 32'(instr_pc), 32'h0);
    checkOutput("ar_valid", 32'(instr_valid), 0);
    checkOutput("ar_align", 32'(align_err), 0);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("ar_restart_rd", 32'(mem_rd), 1);
    checkOutput("ar_restart_addr", 32'(mem_addr), 32'(RPC));
    waitValid(12, n);
    checkOutput("ar_instr0", instr, 32'h8C010004);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
